pair_count_scheduler: RTL

- Shares one serial "11"-pair counting engine between two requesters.
- Each requester presents an nBits-wide word. A round-robin arbiter grants one job at a time, and the sequencer shifts the word through the engine one bit per step.
- Returns the count of adjacent set-bit pairs with a one-cycle ack to the granted requester.
- Sits between the input sources and the binary-to-digit decoder. Steps are paced by a clock-enable tick from the board-level divider; the block does not use a derived slow clock.

---
 rtl/pair_count_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pair_count_scheduler.sv
// Two-requester scheduler around one serial engine that counts adjacent "11" bit pairs.
// Build option SCHED_FIXED_PRIO_EN: requester 0 always wins ties instead of round-robin.
module pair_count_scheduler #(
  parameter int nBits       = 8,
  parameter int nOutputBits = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [nBits-1:0]       data0,
  input  logic [nBits-1:0]       data1,
  output logic                   ack0,
  output logic                   ack1,
  output logic                   grantId,
  output logic                   busy,
  output logic [nOutputBits-1:0] result,
  output logic                   resultValid
);
  // Handshake: reqN is a level held (with dataN stable) until ackN, a one-clock pulse
  // in DONE alongside resultValid; a req still high back in IDLE starts a fresh job.
  localparam int SW = (nBits < 2) ? 2 : nBits;
  localparam int CW = $clog2(nBits + 1);
  localparam logic [CW-1:0]          LAST_STEP = CW'(nBits - 1);
  localparam logic [nOutputBits-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SW-1:0]          shreg_q, shreg_d;
  logic [nOutputBits-1:0] count_q, count_d;
  logic [nOutputBits-1:0] result_q, result_d;
  logic [CW-1:0]          step_q, step_d;
  logic                   grant_q, grant_d;
  logic                   ack0_q, ack0_d;
  logic                   ack1_q, ack1_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   win;

`ifdef SCHED_FIXED_PRIO_EN
  assign win = !req0;
`else
  logic last_grant_q, last_grant_d;
  // On a tie, the requester that did not win last time is served.
  assign win = (req0 && req1) ? !last_grant_q : req1;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    step_d  = step_q;
    grant_d = grant_q;
    result_d = result_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    valid_d = 1'b0;
`ifndef SCHED_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (enable && (req0 || req1)) begin
          grant_d = win;
`ifndef SCHED_FIXED_PRIO_EN
          last_grant_d = win;
`endif
          shreg_d = win ? SW'(data1) : SW'(data0);
          count_d = '0;
          step_d  = '0;
          if (nBits == 1) begin
            // A one-bit word has no pairs, so the job finishes without shifting.
            state_d  = DONE;
            result_d = '0;
            ack0_d   = !win;
            ack1_d   = win;
            valid_d  = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (enable) begin
          if (shreg_q[1:0] == 2'b11 && count_q != COUNT_MAX) count_d = count_q + 1'b1;
          shreg_d = shreg_q >> 1;
          step_d  = step_q + 1'b1;
          if (step_d == LAST_STEP) begin
            state_d  = DONE;
            result_d = count_d;
            ack0_d   = !grant_q;
            ack1_d   = grant_q;
            valid_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      count_q  <= '0;
      step_q   <= '0;
      grant_q  <= 1'b0;
      result_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifndef SCHED_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      count_q  <= count_d;
      step_q   <= step_d;
      grant_q  <= grant_d;
      result_q <= result_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
`ifndef SCHED_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign grantId     = grant_q;
  assign busy        = busy_q;
  assign result      = result_q;
  assign resultValid = valid_q;
endmodule
